// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: single-port memory arbiter between MIPS fetch and data ports.
// Define MEM_ARB_TIMEOUT_EN to abort stalled memory accesses with bus_err.
module mips_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FAIR_LIMIT = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    localparam logic [DATA_W-1:0] DEAD = DATA_W'(32'hDEAD_BEEF);

    state_t     state;
    logic       owner_d;
    logic [2:0] d_streak;
    logic       pick_d;
    logic       timeout;

    // Data wins unless fetch has already waited out FAIR_LIMIT data grants.
    assign pick_d = d_req && !(if_req && d_streak == 3'(FAIR_LIMIT));

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] wait_cnt;
    assign timeout = state == BUSY && !mem_ready && wait_cnt == CW'(TIMEOUT - 1);
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n)
            wait_cnt <= '0;
        else if (state != BUSY)
            wait_cnt <= '0;
        else if (!mem_ready)
            wait_cnt <= wait_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            d_streak  <= 3'd0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            bus_err   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 4'h0;
        end else begin
            case (state)
                IDLE: if (if_req || d_req) begin
                    owner_d   <= pick_d;
                    mem_req   <= 1'b1;
                    mem_we    <= pick_d && d_we;
                    mem_addr  <= pick_d ? d_addr : if_addr;
                    mem_wdata <= pick_d ? d_wdata : '0;
                    mem_be    <= pick_d ? d_be : 4'hF;
                    d_streak  <= (pick_d && if_req) ? d_streak + 3'd1 : 3'd0;
                    state     <= BUSY;
                end
                BUSY: if (mem_ready || timeout) begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    if_ack  <= !owner_d;
                    d_ack   <= owner_d;
                    bus_err <= timeout;
                    if (!owner_d)
                        if_rdata <= timeout ? DEAD : mem_rdata;
                    else if (timeout || !mem_we)
                        d_rdata <= timeout ? DEAD : mem_rdata;
                    state <= ACK;
                end
                ACK: begin
                    if_ack  <= 1'b0;
                    d_ack   <= 1'b0;
                    bus_err <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
